mc_control_v2: RTL

Parametrised control unit for the 8-bit multicycle datapath. It decodes IR[3:0] and sequences all datapath enables and mux selects. Unlike the previous fixed-timing controller, every memory access uses a `mem_ready` handshake, so memory may insert any number of wait states. It also carries saturating cycle and instruction counters for the board LEDs and HEX displays, and it replaces the datapath's ad-hoc counter.

---
 rtl/mc_control_v2_pkg.sv | 52 +++++
 rtl/mc_control_v2_if.sv | 12 +
 rtl/mc_control_v2_sat_counter.sv | 16 +
 rtl/mc_control_v2.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mc_control_v2_pkg.sv
// Shared constants for the multicycle controller: state codes, opcodes,
// ALU operation and ALU operand-B select encodings.
package mc_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_LD_MEM = 4'd2;
  localparam logic [3:0] S_LD_WB  = 4'd3;
  localparam logic [3:0] S_ST_MEM = 4'd4;
  localparam logic [3:0] S_ALU_EX = 4'd5;
  localparam logic [3:0] S_ORI_EX = 4'd6;
  localparam logic [3:0] S_SH_EX  = 4'd7;
  localparam logic [3:0] S_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_STOP   = 4'd10;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_NOP   = 4'b1010;
  localparam logic [3:0] OP_BPZ   = 4'b1101;

  // ori and shift only decode the low three bits; bit 3 is part of the immediate
  localparam logic [2:0] ORI_MATCH   = 3'b111;
  localparam logic [2:0] SHIFT_MATCH = 3'b011;

  localparam logic [2:0] ALU_OP_ADD   = 3'd0;
  localparam logic [2:0] ALU_OP_SUB   = 3'd1;
  localparam logic [2:0] ALU_OP_OR    = 3'd2;
  localparam logic [2:0] ALU_OP_NAND  = 3'd3;
  localparam logic [2:0] ALU_OP_SHIFT = 3'd4;

  localparam logic [2:0] ALU2_R2  = 3'd0;
  localparam logic [2:0] ALU2_ONE = 3'd1;
  localparam logic [2:0] ALU2_SE4 = 3'd2;
  localparam logic [2:0] ALU2_ZE5 = 3'd3;
  localparam logic [2:0] ALU2_ZE3 = 3'd4;

  function automatic logic is_ori(input logic [3:0] op);
    return op[2:0] == ORI_MATCH;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return op[2:0] == SHIFT_MATCH;
  endfunction

endpackage

// File: rtl/mc_control_v2_if.sv
// Memory handshake between the controller (master) and the memory (slave).
// Request (mem_read or mem_write, with addr_sel) is held steady until the memory
// answers mem_ready=1; the access completes on the rising edge where both are high.
interface mc_control_v2_if;
  logic mem_ready;
  logic mem_read;
  logic mem_write;
  logic addr_sel;

  modport master (output mem_read, output mem_write, output addr_sel, input mem_ready);
  modport slave  (input mem_read, input mem_write, input addr_sel, output mem_ready);
endinterface

// File: rtl/mc_control_v2_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= '0;
    else if (inc && q != MAX) q <= q + W'(1);
  end
endmodule

// File: rtl/mc_control_v2.sv
// Multicycle datapath controller: decodes IR[3:0], sequences enables/selects,
// waits on mem_ready for every memory access, and keeps saturating perf counters.
module mc_control_v2
  import mc_pkg::*;
#(
  parameter int         CNT_W       = 16,
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       instr,
  input  logic             N,
  input  logic             Z,
  mc_control_v2_if.master  mem,
  output logic             pc_write,
  output logic             ir_load,
  output logic             r1_sel,
  output logic             mdr_load,
  output logic             r1r2_load,
  output logic             alu1_sel,
  output logic [2:0]       alu2_sel,
  output logic [2:0]       alu_op,
  output logic             alu_out_write,
  output logic             flag_write,
  output logic             rf_write,
  output logic             reg_in,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);
  logic [3:0] state_q, nxt;
  logic       addr_sel_c, mem_read_c, mem_write_c;
  logic       ready;
  logic       taken;

  // Memory completion is masked under reset so reset shows a clean FETCH decode
  assign ready = mem.mem_ready && !reset;
  assign taken = (instr == OP_BZ  &&  Z) ||
                 (instr == OP_BNZ && !Z) ||
                 (instr == OP_BPZ && !N);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= nxt;
  end

  always_comb begin
    nxt           = state_q;
    pc_write      = 1'b0;
    addr_sel_c    = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    ir_load       = 1'b0;
    r1_sel        = 1'b0;
    mdr_load      = 1'b0;
    r1r2_load     = 1'b0;
    alu1_sel      = 1'b0;
    alu2_sel      = ALU2_R2;
    alu_op        = ALU_OP_ADD;
    alu_out_write = 1'b0;
    flag_write    = 1'b0;
    rf_write      = 1'b0;
    reg_in        = 1'b0;
    case (state_q)
      S_FETCH: begin
        addr_sel_c = 1'b1;
        mem_read_c = 1'b1;
        if (ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          alu2_sel = ALU2_ONE;
          nxt      = S_DECODE;
        end
      end
      S_DECODE: begin
        r1r2_load = 1'b1;
        r1_sel    = is_ori(instr);
        if (instr == OP_LOAD)                                    nxt = S_LD_MEM;
        else if (instr == OP_STORE)                              nxt = S_ST_MEM;
        else if (instr == OP_ADD || instr == OP_SUB || instr == OP_NAND) nxt = S_ALU_EX;
        else if (is_ori(instr))                                  nxt = S_ORI_EX;
        else if (is_shift(instr))                                nxt = S_SH_EX;
        else if (instr == OP_BZ || instr == OP_BNZ || instr == OP_BPZ)   nxt = S_BRANCH;
        else if (instr == OP_STOP)                               nxt = S_STOP;
        else if (instr == OP_NOP)                                nxt = S_FETCH;
        else                                                     nxt = S_FETCH;
      end
      S_LD_MEM: begin
        mem_read_c = 1'b1;
        if (ready) begin
          mdr_load = 1'b1;
          nxt      = S_LD_WB;
        end
      end
      S_LD_WB: begin
        reg_in   = 1'b1;
        rf_write = 1'b1;
        nxt      = S_FETCH;
      end
      S_ST_MEM: begin
        mem_write_c = 1'b1;
        if (ready) nxt = S_FETCH;
      end
      S_ALU_EX: begin
        alu1_sel      = 1'b1;
        alu2_sel      = ALU2_R2;
        alu_op        = (instr == OP_SUB)  ? ALU_OP_SUB  :
                        (instr == OP_NAND) ? ALU_OP_NAND : ALU_OP_ADD;
        alu_out_write = 1'b1;
        flag_write    = 1'b1;
        nxt           = S_WB;
      end
      S_ORI_EX: begin
        alu1_sel      = 1'b1;
        alu2_sel      = ALU2_ZE5;
        alu_op        = ALU_OP_OR;
        alu_out_write = 1'b1;
        flag_write    = 1'b1;
        nxt           = S_WB;
      end
      S_SH_EX: begin
        alu1_sel      = 1'b1;
        alu2_sel      = ALU2_ZE3;
        alu_op        = ALU_OP_SHIFT;
        alu_out_write = 1'b1;
        flag_write    = 1'b1;
        nxt           = S_WB;
      end
      S_WB: begin
        rf_write = 1'b1;
        r1_sel   = is_ori(instr);
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        alu2_sel = ALU2_SE4;
        pc_write = taken;
        nxt      = S_FETCH;
      end
      S_STOP:  nxt = S_STOP;
      default: nxt = S_FETCH;
    endcase
  end

  assign mem.addr_sel  = addr_sel_c;
  assign mem.mem_read  = mem_read_c;
  assign mem.mem_write = mem_write_c;
  assign state         = state_q;
  assign halted        = (state_q == S_STOP);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (state_q != S_STOP),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (state_q == S_DECODE),
    .q     (instr_count)
  );
endmodule
